apb_event_completer: RTL and testbench

//  APB3 completer: the receiving end of the event-count write stream.
//  - Accepts writes to three event mailboxes (A/B/C); each write adds PWDATA to a per-event accumulator.
//  - Supports read-back, clear, programmable wait states, PSLVERR on unmapped addresses,
//    and a sticky protocol-violation flag.
//  - Sits on the peripheral bus opposite the event-to-APB requester.

---
 rtl/apb_event_completer.sv | 150 +++++++++++++++
 tb/tb_apb_event_completer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/apb_event_completer.sv
// APB3 completer accumulating event counts into three mailboxes (A/B/C) with
// wait states, PSLVERR on unmapped addresses and a sticky protocol flag.
// Optional READ_CLEAR_EN: completed reads of A/B/C clear that accumulator.
module apb_event_completer #(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             apb_psel_i,
    input  logic             apb_penable_i,
    input  logic [31:0]      apb_paddr_i,
    input  logic             apb_pwrite_i,
    input  logic [31:0]      apb_pwdata_i,
    output logic             apb_pready_o,
    output logic [31:0]      apb_prdata_o,
    output logic             apb_pslverr_o,
    output logic [CNT_W-1:0] acc_a_o,
    output logic [CNT_W-1:0] acc_b_o,
    output logic [CNT_W-1:0] acc_c_o,
    output logic [2:0]       ovf_o,
    output logic             proto_err_o
);
    localparam logic [31:0] ADDR_A    = 32'hABBA_0000;
    localparam logic [31:0] ADDR_B    = 32'hBAFF_0000;
    localparam logic [31:0] ADDR_C    = 32'hCAFE_0000;
    localparam logic [31:0] ADDR_CTRL = 32'hC1EA_0000;
    localparam int          WCW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    state_t           state, state_nxt;
    logic [WCW-1:0]   wait_cnt;
    logic [31:0]      lat_addr, lat_wdata;
    logic             lat_write;
    logic             acc_cyc, changed, proto_set, hi_nz, clr_all, hit_ctrl, mapped;
    logic [2:0]       sel, wr_hit, rd_hit;
    logic [CNT_W-1:0] acc [3];
    logic [CNT_W:0]   sum [3];
    logic             ovf [3];

    assign sel      = {apb_paddr_i == ADDR_C, apb_paddr_i == ADDR_B, apb_paddr_i == ADDR_A};
    assign hit_ctrl = (apb_paddr_i == ADDR_CTRL);
    assign mapped   = |sel | hit_ctrl;

    // The first access cycle is seen while the register still holds ST_SETUP,
    // so a zero-wait transfer completes in two bus cycles.
    assign acc_cyc      = apb_psel_i & apb_penable_i & ((state == ST_SETUP) | (state == ST_ACCESS));
    assign apb_pready_o = acc_cyc & (wait_cnt == WCW'(WAIT_CYCLES));
    assign changed      = (apb_paddr_i != lat_addr) | (apb_pwrite_i != lat_write) |
                          (apb_pwdata_i != lat_wdata);

    always_comb begin
        state_nxt = state;
        proto_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (apb_psel_i & ~apb_penable_i)     state_nxt = ST_SETUP;
                else if (apb_psel_i & apb_penable_i) proto_set = 1'b1;
            end
            ST_SETUP, ST_ACCESS: begin
                if (apb_psel_i & apb_penable_i) begin
                    state_nxt = apb_pready_o ? ST_IDLE : ST_ACCESS;
                    proto_set = changed;
                end else begin
                    state_nxt = ST_IDLE;
                    proto_set = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_write   <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (acc_cyc & ~apb_pready_o) ? wait_cnt + WCW'(1) : '0;
            if (proto_set) proto_err_o <= 1'b1;
            if (state == ST_IDLE && apb_psel_i && !apb_penable_i) begin
                lat_addr  <= apb_paddr_i;
                lat_wdata <= apb_pwdata_i;
                lat_write <= apb_pwrite_i;
            end
        end
    end

    // Increment bits above the accumulator width force saturation.
    generate
        if (CNT_W < 32) begin : g_hi
            assign hi_nz = |apb_pwdata_i[31:CNT_W];
        end else begin : g_nohi
            assign hi_nz = 1'b0;
        end
    endgenerate

    assign wr_hit  = sel & {3{apb_pready_o & apb_pwrite_i}};
    assign rd_hit  = sel & {3{apb_pready_o & ~apb_pwrite_i}};
    assign clr_all = apb_pready_o & apb_pwrite_i & hit_ctrl & apb_pwdata_i[0];

    for (genvar i = 0; i < 3; i++) begin : g_acc
        assign sum[i] = {1'b0, acc[i]} + {1'b0, apb_pwdata_i[CNT_W-1:0]};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                acc[i] <= '0;
                ovf[i] <= 1'b0;
            end else if (clr_all) begin
                acc[i] <= '0;
                ovf[i] <= 1'b0;
            end else if (wr_hit[i]) begin
                if (sum[i][CNT_W] | hi_nz) begin
                    acc[i] <= '1;
                    ovf[i] <= 1'b1;
                end else begin
                    acc[i] <= sum[i][CNT_W-1:0];
                end
            end
`ifdef READ_CLEAR_EN
            else if (rd_hit[i]) begin
                acc[i] <= '0;
                ovf[i] <= 1'b0;
            end
`endif
        end
    end

    assign acc_a_o = acc[0];
    assign acc_b_o = acc[1];
    assign acc_c_o = acc[2];
    assign ovf_o   = {ovf[2], ovf[1], ovf[0]};

    always_comb begin
        apb_prdata_o = '0;
        if (rd_hit[0])      apb_prdata_o = 32'(acc[0]);
        else if (rd_hit[1]) apb_prdata_o = 32'(acc[1]);
        else if (rd_hit[2]) apb_prdata_o = 32'(acc[2]);
        else if (apb_pready_o & ~apb_pwrite_i & hit_ctrl)
            apb_prdata_o = {28'h0, proto_err_o, ovf_o};
    end

    assign apb_pslverr_o = apb_pready_o & ~mapped;

endmodule

// File: tb/tb_apb_event_completer.sv
// Directed self-checking bench for apb_event_completer (WAIT_CYCLES=2, CNT_W=16).
// Expectations follow READ_CLEAR_EN when the bench is built with it defined.
module tb_apb_event_completer;
    localparam logic [31:0] A = 32'hABBA_0000, B = 32'hBAFF_0000, C = 32'hCAFE_0000;
    localparam logic [31:0] CTRL = 32'hC1EA_0000, UNM = 32'h1234_0000;

    logic        clk = 1'b0, reset = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic        pready, pslverr, proto_err;
    logic [31:0] prdata;
    logic [15:0] acc_a, acc_b, acc_c;
    logic [2:0]  ovf;
    int          checks = 0, errors = 0;

    apb_event_completer #(.WAIT_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .apb_psel_i(psel), .apb_penable_i(penable), .apb_paddr_i(paddr),
        .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata),
        .apb_pready_o(pready), .apb_prdata_o(prdata), .apb_pslverr_o(pslverr),
        .acc_a_o(acc_a), .acc_b_o(acc_b), .acc_c_o(acc_c),
        .ovf_o(ovf), .proto_err_o(proto_err)
    );

    always #5 clk = ~clk;

    // Called at posedge+1; returns at posedge+1 after the completion edge, bus left selected.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int n);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(posedge clk); #1 penable = 1'b1;
        n = 0; rd = '0; er = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); n++;
            if (pready === 1'b1) begin rd = prdata; er = pslverr; break; end
        end
        checks++;
        if (pready !== 1'b1) begin
            errors++; $display("FAIL xfer_timeout: addr %h pready %b after %0d cycles, want 1", a, pready, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic bus_idle();
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if ({pready, pslverr, prdata} !== 34'h0) begin errors++; $display("FAIL reset_bus: got %h want 0", {pready, pslverr, prdata}); end
        checks++; if ({acc_a, acc_b, acc_c} !== 48'h0) begin errors++; $display("FAIL reset_acc: got %h want 0", {acc_a, acc_b, acc_c}); end
        checks++; if ({ovf, proto_err} !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h want 0", {ovf, proto_err}); end
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_a();
        logic [31:0] rd; logic er; int n;
        xfer(A, 1'b1, 32'd5, rd, er, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL write_latency: got %0d want 3", n); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL write_a_err: got %b want 0", er); end
        bus_idle();
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL idle_pready: got %b want 0", pready); end
        xfer(A, 1'b1, 32'd3, rd, er, n); bus_idle();
        checks++; if (acc_a !== 16'd8) begin errors++; $display("FAIL acc_a_sum: got %0d want 8", acc_a); end
        xfer(A, 1'b0, 32'd0, rd, er, n); bus_idle();
        checks++; if ({er, rd} !== {1'b0, 32'd8}) begin errors++; $display("FAIL read_a: got %b/%h want 0/8", er, rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int n;
        xfer(A, 1'b1, 32'd1, rd, er, n);
        xfer(A, 1'b1, 32'd2, rd, er, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_latency: got %0d want 3", n); end
        bus_idle();
        checks++; if (acc_a !== 16'd11) begin errors++; $display("FAIL b2b_acc_a: got %0d want 11", acc_a); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL b2b_proto: got %b want 0", proto_err); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd; logic er; int n;
        xfer(UNM, 1'b1, 32'd77, rd, er, n); bus_idle();
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL unm_wr_err: got %b want 1", er); end
        xfer(UNM, 1'b0, 32'd0, rd, er, n); bus_idle();
        checks++; if ({er, rd} !== {1'b1, 32'd0}) begin errors++; $display("FAIL unm_rd: got %b/%h want 1/0", er, rd); end
        checks++; if ({acc_a, acc_b, acc_c, ovf} !== {16'd11, 16'd0, 16'd0, 3'b000}) begin
            errors++; $display("FAIL unm_state: got %h/%h/%h/%b want b/0/0/000", acc_a, acc_b, acc_c, ovf); end
    endtask

    task automatic test_saturate();
        logic [31:0] rd; logic er; int n;
        xfer(B, 1'b1, 32'hFFF0, rd, er, n);
        xfer(B, 1'b1, 32'h20, rd, er, n); bus_idle();
        checks++; if ({acc_b, ovf} !== {16'hFFFF, 3'b010}) begin errors++; $display("FAIL sat_b: got %h/%b want ffff/010", acc_b, ovf); end
        xfer(CTRL, 1'b0, 32'd0, rd, er, n); bus_idle();
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL ctrl_rd_ovf: got %h want 2", rd); end
        xfer(B, 1'b1, 32'd0, rd, er, n); bus_idle();
        checks++; if ({er, acc_b} !== {1'b0, 16'hFFFF}) begin errors++; $display("FAIL zero_wr: got %b/%h want 0/ffff", er, acc_b); end
        xfer(C, 1'b1, 32'h0001_0000, rd, er, n); bus_idle();
        checks++; if ({acc_c, ovf} !== {16'hFFFF, 3'b110}) begin errors++; $display("FAIL sat_hi_bits: got %h/%b want ffff/110", acc_c, ovf); end
        xfer(CTRL, 1'b1, 32'h2, rd, er, n); bus_idle();
        checks++; if ({acc_a, ovf} !== {16'd11, 3'b110}) begin errors++; $display("FAIL ctrl_bit1: got %h/%b want b/110", acc_a, ovf); end
        xfer(CTRL, 1'b1, 32'h1, rd, er, n); bus_idle();
        checks++; if ({acc_a, acc_b, acc_c, ovf} !== 51'h0) begin errors++; $display("FAIL ctrl_clear: got %h/%h/%h/%b want 0", acc_a, acc_b, acc_c, ovf); end
    endtask

    task automatic test_read_clear();
        logic [31:0] rd; logic er; int n;
        logic [15:0] exp_after;
`ifdef READ_CLEAR_EN
        exp_after = 16'd0;
`else
        exp_after = 16'd9;
`endif
        xfer(A, 1'b1, 32'd9, rd, er, n); bus_idle();
        xfer(A, 1'b0, 32'd0, rd, er, n); bus_idle();
        checks++; if (rd !== 32'd9) begin errors++; $display("FAIL rc_first_rd: got %0d want 9", rd); end
        checks++; if (acc_a !== exp_after) begin errors++; $display("FAIL rc_acc_a: got %0d want %0d", acc_a, exp_after); end
        xfer(A, 1'b0, 32'd0, rd, er, n); bus_idle();
        checks++; if (rd !== 32'(exp_after)) begin errors++; $display("FAIL rc_second_rd: got %0d want %0d", rd, exp_after); end
    endtask

    task automatic test_protocol();
        logic [31:0] rd; logic er; int n;
        psel = 1'b1; penable = 1'b1; paddr = B; pwrite = 1'b1; pwdata = 32'd50;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        checks++; if ({proto_err, acc_b} !== {1'b1, 16'd0}) begin errors++; $display("FAIL proto_set: got %b/%h want 1/0", proto_err, acc_b); end
        @(posedge clk); #1;
        xfer(B, 1'b1, 32'd4, rd, er, n); bus_idle();
        checks++; if ({proto_err, acc_b} !== {1'b1, 16'd4}) begin errors++; $display("FAIL proto_sticky: got %b/%h want 1/4", proto_err, acc_b); end
        xfer(CTRL, 1'b0, 32'd0, rd, er, n); bus_idle();
        checks++; if (rd !== 32'h8) begin errors++; $display("FAIL ctrl_rd_proto: got %h want 8", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int n;
        psel = 1'b1; penable = 1'b0; paddr = C; pwrite = 1'b1; pwdata = 32'd7;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #2 reset = 1'b1;
        #1;
        checks++; if ({pready, acc_c} !== 17'h0) begin errors++; $display("FAIL midrst_abort: got %b/%h want 0/0", pready, acc_c); end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        checks++; if ({proto_err, acc_b} !== 17'h0) begin errors++; $display("FAIL midrst_clear: got %b/%h want 0/0", proto_err, acc_b); end
        xfer(C, 1'b1, 32'd7, rd, er, n); bus_idle();
        checks++; if (acc_c !== 16'd7) begin errors++; $display("FAIL midrst_rewrite: got %0d want 7", acc_c); end
    endtask

    initial begin
        test_reset();
        test_write_a();
        test_back_to_back();
        test_unmapped();
        test_saturate();
        test_read_clear();
        test_protocol();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
